// File: rtl/regwb_checker.sv
// Write-back port monitor: shadows register writes during a run, then checks them against a loaded table.
// Optional WB signature is enabled by defining REGWB_CHECKER_SIGNATURE_EN.
module regwb_checker #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int REG_ADDR_W = $clog2(NUM_REGS),
    parameter int MAX_CYCLES = 90,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  wb_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_write_reg,
    input  logic [DATA_WIDTH-1:0] wb_write_data,
    input  logic                  halt,
    input  logic                  exp_we,
    input  logic [REG_ADDR_W-1:0] exp_addr,
    input  logic [DATA_WIDTH-1:0] exp_data,
    input  logic [NUM_REGS-1:0]   check_mask,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  timeout,
    output logic [REG_ADDR_W:0]   fail_count,
    output logic [REG_ADDR_W-1:0] first_fail_reg,
    output logic [CNT_W-1:0]      cycle_count,
    output logic [CNT_W-1:0]      wb_count,
    output logic [DATA_WIDTH-1:0] signature
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_CHECK, S_DONE} state_t;

    state_t                              state_q, state_d;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] shadow_q, shadow_d;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] exp_q, exp_d;
    logic [REG_ADDR_W-1:0]               idx_q, idx_d;
    logic [REG_ADDR_W-1:0]               first_fail_q, first_fail_d;
    logic [REG_ADDR_W:0]                 fail_count_q, fail_count_d;
    logic [CNT_W-1:0]                    cycle_count_q, cycle_count_d;
    logic [CNT_W-1:0]                    wb_count_q, wb_count_d;
    logic                                busy_q, busy_d, done_q, done_d;
    logic                                pass_q, pass_d, timeout_q, timeout_d;
    logic                                wb_hit, exp_hit, mismatch;
`ifdef REGWB_CHECKER_SIGNATURE_EN
    logic [DATA_WIDTH-1:0]               sig_q, sig_d;
    assign signature = sig_q;
`else
    assign signature = '0;
`endif

    assign wb_hit   = wb_reg_write && (wb_write_reg != '0) && (32'(wb_write_reg) < NUM_REGS);
    assign exp_hit  = exp_we && (32'(exp_addr) < NUM_REGS);
    assign mismatch = check_mask[idx_q] && (shadow_q[idx_q] != exp_q[idx_q]);

    always_comb begin
        state_d       = state_q;
        shadow_d      = shadow_q;
        exp_d         = exp_q;
        idx_d         = idx_q;
        first_fail_d  = first_fail_q;
        fail_count_d  = fail_count_q;
        cycle_count_d = cycle_count_q;
        wb_count_d    = wb_count_q;
        busy_d        = busy_q;
        done_d        = done_q;
        pass_d        = pass_q;
        timeout_d     = timeout_q;
`ifdef REGWB_CHECKER_SIGNATURE_EN
        sig_d         = sig_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (exp_hit) exp_d[exp_addr] = exp_data;
                if (start) begin
                    state_d       = S_RUN;
                    shadow_d      = '0;
                    idx_d         = '0;
                    first_fail_d  = '0;
                    fail_count_d  = '0;
                    cycle_count_d = '0;
                    wb_count_d    = '0;
                    busy_d        = 1'b1;
                    done_d        = 1'b0;
                    pass_d        = 1'b0;
                    timeout_d     = 1'b0;
`ifdef REGWB_CHECKER_SIGNATURE_EN
                    sig_d         = '0;
`endif
                end
            end
            S_RUN: begin
                if (cycle_count_q != '1) cycle_count_d = cycle_count_q + 1'b1;
                if (wb_hit) begin
                    shadow_d[wb_write_reg] = wb_write_data;
                    if (wb_count_q != '1) wb_count_d = wb_count_q + 1'b1;
`ifdef REGWB_CHECKER_SIGNATURE_EN
                    sig_d = {sig_q[DATA_WIDTH-2:0], sig_q[DATA_WIDTH-1]}
                            ^ wb_write_data ^ DATA_WIDTH'(wb_write_reg);
`endif
                end
                // halt has priority over the budget, so timeout only flags a pure budget exit
                if (halt || (cycle_count_q == CNT_W'(MAX_CYCLES - 1))) begin
                    state_d   = S_CHECK;
                    idx_d     = '0;
                    timeout_d = !halt;
                end
            end
            S_CHECK: begin
                if (mismatch) begin
                    if (fail_count_q == '0) first_fail_d = idx_q;
                    if (fail_count_q != '1) fail_count_d = fail_count_q + 1'b1;
                end
                if (idx_q == REG_ADDR_W'(NUM_REGS - 1)) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (fail_count_d == '0);
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            shadow_q      <= '0;
            exp_q         <= '0;
            idx_q         <= '0;
            first_fail_q  <= '0;
            fail_count_q  <= '0;
            cycle_count_q <= '0;
            wb_count_q    <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            timeout_q     <= 1'b0;
`ifdef REGWB_CHECKER_SIGNATURE_EN
            sig_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            shadow_q      <= shadow_d;
            exp_q         <= exp_d;
            idx_q         <= idx_d;
            first_fail_q  <= first_fail_d;
            fail_count_q  <= fail_count_d;
            cycle_count_q <= cycle_count_d;
            wb_count_q    <= wb_count_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
            timeout_q     <= timeout_d;
`ifdef REGWB_CHECKER_SIGNATURE_EN
            sig_q         <= sig_d;
`endif
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign timeout        = timeout_q;
    assign fail_count     = fail_count_q;
    assign first_fail_reg = first_fail_q;
    assign cycle_count    = cycle_count_q;
    assign wb_count       = wb_count_q;

endmodule

// File: tb/tb_regwb_checker.sv
// Bench for regwb_checker: run-level reference model compared every cycle, plus directed literal checks.
module tb_regwb_checker;
    localparam int DW = 32, NR = 32, AW = 5, MC = 90, CW = 16;

    logic clk = 1'b0, reset = 1'b0, start = 1'b0, wb_reg_write = 1'b0, halt = 1'b0, exp_we = 1'b0;
    logic [AW-1:0] wb_write_reg = '0, exp_addr = '0;
    logic [DW-1:0] wb_write_data = '0, exp_data = '0;
    logic [NR-1:0] check_mask = '0;
    logic busy, done, pass, timeout;
    logic [AW:0] fail_count;
    logic [AW-1:0] first_fail_reg;
    logic [CW-1:0] cycle_count, wb_count;
    logic [DW-1:0] signature;

    regwb_checker #(.DATA_WIDTH(DW), .NUM_REGS(NR), .REG_ADDR_W(AW), .MAX_CYCLES(MC), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .wb_reg_write(wb_reg_write),
        .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data), .halt(halt),
        .exp_we(exp_we), .exp_addr(exp_addr), .exp_data(exp_data), .check_mask(check_mask),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout), .fail_count(fail_count),
        .first_fail_reg(first_fail_reg), .cycle_count(cycle_count), .wb_count(wb_count),
        .signature(signature));

    always #5 clk = ~clk;

    int errors = 0, checks = 0;

    // ---------------- reference model (run-level view) ----------------
    // mode: 0 idle, 1 running, 2 checking, 3 finished
    int          m_known = 0, m_mode = 0, m_cyc = 0, m_wb = 0, m_fail = 0, m_first = 0, m_left = 0;
    int          p_fail = 0, p_first = 0;
    bit          m_pass = 0, m_to = 0;
    logic [DW-1:0] m_sig = '0;
    logic [DW-1:0] m_exp [NR];
    logic [DW-1:0] m_sh  [NR];

    initial forever begin
        @(posedge clk);
        if (!reset) begin
            m_known = 1; m_mode = 0; m_cyc = 0; m_wb = 0; m_fail = 0; m_first = 0;
            m_pass = 0; m_to = 0; m_sig = '0;
            for (int i = 0; i < NR; i++) begin m_exp[i] = '0; m_sh[i] = '0; end
        end else if (m_known == 1) begin
            if (m_mode == 0 || m_mode == 3) begin
                if (exp_we) m_exp[exp_addr] = exp_data;
                if (start) begin
                    m_mode = 1; m_cyc = 0; m_wb = 0; m_fail = 0; m_first = 0;
                    m_pass = 0; m_to = 0; m_sig = '0;
                    for (int i = 0; i < NR; i++) m_sh[i] = '0;
                end
            end else if (m_mode == 1) begin
                m_cyc++;
                if (wb_reg_write && wb_write_reg != 0) begin
                    m_sh[wb_write_reg] = wb_write_data;
                    m_wb++;
`ifdef REGWB_CHECKER_SIGNATURE_EN
                    m_sig = ((m_sig << 1) | (m_sig >> (DW - 1))) ^ wb_write_data ^ {27'd0, wb_write_reg};
`endif
                end
                if (halt || m_cyc == MC) begin
                    m_mode = 2; m_to = !halt; m_left = NR; p_fail = 0; p_first = 0;
                    for (int i = 0; i < NR; i++)
                        if (check_mask[i] && m_sh[i] != m_exp[i]) begin
                            if (p_fail == 0) p_first = i;
                            p_fail++;
                        end
                end
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_mode = 3; m_fail = p_fail; m_first = p_first; m_pass = (p_fail == 0);
                end
            end
        end
    end

    // ---------------- compare process ----------------
    int lit_id = 0;
    int l_busy, l_done, l_pass, l_to, l_fail, l_first, l_cyc, l_wb;
    longint l_sig;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (m_known == 1) begin
            chk("busy", 64'(busy), 64'(m_mode == 1 || m_mode == 2));
            chk("done", 64'(done), 64'(m_mode == 3));
            chk("pass", 64'(pass), 64'(m_pass));
            chk("timeout", 64'(timeout), 64'(m_to));
            chk("cycle_count", 64'(cycle_count), 64'(m_cyc));
            chk("wb_count", 64'(wb_count), 64'(m_wb));
            chk("signature", 64'(signature), 64'(m_sig));
            if (m_mode != 2) begin
                chk("fail_count", 64'(fail_count), 64'(m_fail));
                chk("first_fail_reg", 64'(first_fail_reg), 64'(m_first));
            end
        end
        if (lit_id != 0) begin
            if (l_busy  >= 0) chk($sformatf("t%0d_busy", lit_id), 64'(busy), 64'(l_busy));
            if (l_done  >= 0) chk($sformatf("t%0d_done", lit_id), 64'(done), 64'(l_done));
            if (l_pass  >= 0) chk($sformatf("t%0d_pass", lit_id), 64'(pass), 64'(l_pass));
            if (l_to    >= 0) chk($sformatf("t%0d_timeout", lit_id), 64'(timeout), 64'(l_to));
            if (l_fail  >= 0) chk($sformatf("t%0d_fail_count", lit_id), 64'(fail_count), 64'(l_fail));
            if (l_first >= 0) chk($sformatf("t%0d_first_fail", lit_id), 64'(first_fail_reg), 64'(l_first));
            if (l_cyc   >= 0) chk($sformatf("t%0d_cycle_count", lit_id), 64'(cycle_count), 64'(l_cyc));
            if (l_wb    >= 0) chk($sformatf("t%0d_wb_count", lit_id), 64'(wb_count), 64'(l_wb));
            if (l_sig   >= 0) chk($sformatf("t%0d_signature", lit_id), 64'(signature), 64'(l_sig));
        end
    end

    // ---------------- driver ----------------
    task automatic tick(); @(posedge clk); #1; endtask

    task automatic lit_clear();
        l_busy = -1; l_done = -1; l_pass = -1; l_to = -1; l_fail = -1;
        l_first = -1; l_cyc = -1; l_wb = -1; l_sig = -1;
    endtask

    task automatic expect_lit(input int id);
        lit_id = id;
        @(negedge clk); #1;
        lit_id = 0;
        lit_clear();
    endtask

    task automatic load_exp(input int a, input logic [DW-1:0] d);
        exp_we = 1; exp_addr = AW'(a); exp_data = d; tick(); exp_we = 0;
    endtask

    task automatic wb(input int r, input logic [DW-1:0] d);
        wb_reg_write = 1; wb_write_reg = AW'(r); wb_write_data = d; tick(); wb_reg_write = 0;
    endtask

    task automatic pulse_start(); start = 1; tick(); start = 0; endtask
    task automatic pulse_halt();  halt = 1;  tick(); halt = 0;  endtask

    // bounded wait; a missed done shows up as a failed literal done check
    task automatic wait_done();
        for (int i = 0; i < 300; i++) begin
            if (done) break;
            tick();
        end
    endtask

    task automatic prog1(input logic [DW-1:0] v8);
        wb(3, 0); wb(4, 30); wb(5, 30); wb(6, 32'hFFFF_FFE1); wb(7, 1); wb(8, v8); wb(9, 5);
    endtask

    initial begin
        lit_clear();
        tick(); tick();
        l_busy = 0; l_done = 0; l_pass = 0; l_to = 0; l_fail = 0; l_first = 0;
        l_cyc = 0; l_wb = 0; l_sig = 0;
        expect_lit(0 + 100);
        reset = 1; tick();

        // test 1: clean program
        load_exp(3, 0); load_exp(4, 30); load_exp(5, 30); load_exp(6, 32'hFFFF_FFE1);
        load_exp(7, 1); load_exp(8, 80); load_exp(9, 5);
        check_mask = 32'h0000_03F8;
        pulse_start(); prog1(80); pulse_halt();
        wait_done();
        l_done = 1; l_pass = 1; l_fail = 0; l_to = 0; l_cyc = 8; l_wb = 7;
        expect_lit(1);

        // test 2: $8 wrong
        pulse_start(); prog1(81); pulse_halt();
        wait_done();
        l_done = 1; l_pass = 0; l_fail = 1; l_first = 8; l_to = 0;
        expect_lit(2);

        // test 3: budget exit
        pulse_start();
        wait_done();
        l_done = 1; l_to = 1; l_cyc = 90; l_wb = 0;
        expect_lit(3);

        // test 4: $0 writes dropped, last write to $3 wins
        load_exp(0, 0); load_exp(3, 0);
        check_mask = 32'h0000_0009;
        pulse_start(); wb(0, 7); wb(3, 5); wb(3, 0); pulse_halt();
        wait_done();
        l_done = 1; l_wb = 2; l_pass = 1; l_fail = 0;
        expect_lit(4);

        // test 6: signature
        pulse_start(); wb(1, 32'h10); pulse_halt();
        wait_done();
`ifdef REGWB_CHECKER_SIGNATURE_EN
        l_sig = 32'h11;
`else
        l_sig = 0;
`endif
        l_wb = 1;
        expect_lit(6);

        // test 5a: start and exp_we during RUN are ignored
        check_mask = 32'h0000_0008;
        pulse_start();
        start = 1; exp_we = 1; exp_addr = 3; exp_data = 32'h55; tick();
        start = 0; exp_we = 0;
        pulse_halt();
        wait_done();
        l_done = 1; l_pass = 1; l_cyc = 2;
        expect_lit(5);

        // test 5b: reset in the middle of CHECK
        pulse_start(); pulse_halt();
        repeat (5) tick();
        reset = 0; tick(); reset = 1;
        l_busy = 0; l_done = 0; l_pass = 0; l_to = 0; l_fail = 0; l_first = 0;
        l_cyc = 0; l_wb = 0; l_sig = 0;
        expect_lit(7);

        // randomized runs
        for (int r = 0; r < 40; r++) begin
            check_mask = $urandom;
            for (int k = 0; k < int'($urandom_range(0, 4)); k++)
                load_exp(int'($urandom_range(0, 31)), DW'($urandom_range(0, 3)));
            start = 1;
            if ($urandom_range(0, 1) == 1) begin
                exp_we = 1; exp_addr = AW'($urandom_range(0, 31)); exp_data = DW'($urandom_range(0, 3));
            end
            tick(); start = 0; exp_we = 0;
            for (int i = 0; i < 100; i++) begin
                wb_reg_write  = 1'($urandom_range(0, 1));
                wb_write_reg  = AW'($urandom_range(0, 31));
                wb_write_data = DW'($urandom_range(0, 3));
                halt   = ($urandom_range(0, 19) == 0);
                start  = ($urandom_range(0, 15) == 0);
                exp_we = ($urandom_range(0, 15) == 0);
                exp_addr = AW'($urandom_range(0, 31));
                exp_data = DW'($urandom_range(0, 3));
                tick();
                if (halt) break;
            end
            halt = 0; start = 0; exp_we = 0;
            wb_reg_write = 1'($urandom_range(0, 1));
            wait_done();
            wb_reg_write = 0;
            l_done = 1;
            expect_lit(200 + r);
        end

        tick(); tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
